genome_fitness_ctrl: RTL and testbench

//  Sequencer for the evolvable LUT grid (newGenetico array). Loads one chromosome serially (LUT tables + output-mux selectors).

---
 rtl/genome_fitness_ctrl.sv | 150 +++++++++++++++
 tb/tb_genome_fitness_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/genome_fitness_ctrl.sv
// Evaluation sequencer for the evolvable LUT grid: loads a chromosome, sweeps all input vectors, counts matching output bits.
// Optional early abort on too many mismatches: define FIT_ABORT_EN (adds the aborted output).
module genome_fitness_ctrl #(
  parameter  int ROW      = 4,
  parameter  int COL      = 4,
  parameter  int IN       = 4,
  parameter  int OUT      = 4,
  parameter  int CFG_W    = 32,
  parameter  int SETTLE   = 2,
  parameter  int MAX_ERR  = 8,
  localparam int SEL_W    = $clog2(ROW*COL),
  localparam int CFG_BITS = ROW*COL*16 + OUT*SEL_W,
  localparam int BEATS    = (CFG_BITS + CFG_W - 1) / CFG_W,
  localparam int FW       = $clog2((2**IN)*OUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    reuse,
  input  logic                    cfg_valid,
  input  logic [CFG_W-1:0]        cfg_data,
  output logic                    cfg_ready,
  output logic [ROW*COL*16-1:0]   saidas_LE,
  output logic [OUT*SEL_W-1:0]    out_chrom,
  output logic [IN-1:0]           inp,
  input  logic [OUT-1:0]          out,
  output logic [IN-1:0]           tgt_addr,
  input  logic [OUT-1:0]          tgt_data,
  output logic                    busy,
  output logic                    done,
`ifdef FIT_ABORT_EN
  output logic                    aborted,
`endif
  output logic [FW-1:0]           fitness
);

  localparam int BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  state_t               state_q;
  logic [CFG_BITS-1:0]  chrom_q, chrom_d;
  logic [BW-1:0]        beat_q;
  logic [IN-1:0]        vec_q;
  logic [STW-1:0]       set_q;
  logic [FW-1:0]        fit_q;
  logic                 busy_q, done_q, cfg_ready_q;
  logic [OUT-1:0]       diff;
  logic [FW-1:0]        miss, hit;
  logic                 sample, last_vec, stop_early;

  assign saidas_LE = chrom_q[ROW*COL*16-1:0];
  assign out_chrom = chrom_q[CFG_BITS-1 -: OUT*SEL_W];
  assign inp       = vec_q;
  assign tgt_addr  = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = cfg_ready_q;
  assign fitness   = fit_q;
  assign sample    = (set_q == STW'(SETTLE));
  assign last_vec  = (vec_q == {IN{1'b1}});

  // Beat b lands at chromosome bits [b*CFG_W +: CFG_W]; bits past CFG_BITS simply have no target.
  always_comb begin
    chrom_d = chrom_q;
    for (int i = 0; i < CFG_BITS; i++)
      if (i / CFG_W == int'(beat_q)) chrom_d[i] = cfg_data[i % CFG_W];
  end

  always_comb begin
    diff = out ^ tgt_data;
    miss = '0;
    for (int k = 0; k < OUT; k++) miss = miss + FW'(diff[k]);
    hit = FW'(OUT) - miss;
  end

`ifdef FIT_ABORT_EN
  logic [FW-1:0] err_q, err_d;
  logic          aborted_q;
  assign err_d      = err_q + miss;
  assign stop_early = (int'(err_d) > MAX_ERR);
  assign aborted    = aborted_q;
`else
  assign stop_early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      chrom_q     <= '0;
      beat_q      <= '0;
      vec_q       <= '0;
      set_q       <= '0;
      fit_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
`ifdef FIT_ABORT_EN
      err_q       <= '0;
      aborted_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          fit_q  <= '0;
          vec_q  <= '0;
          set_q  <= '0;
          beat_q <= '0;
          busy_q <= 1'b1;
`ifdef FIT_ABORT_EN
          err_q     <= '0;
          aborted_q <= 1'b0;
`endif
          if (reuse) state_q <= EVAL;
          else begin
            state_q     <= LOAD;
            cfg_ready_q <= 1'b1;
          end
        end
        LOAD: if (cfg_valid) begin
          chrom_q <= chrom_d;
          if (beat_q == BW'(BEATS - 1)) begin
            state_q     <= EVAL;
            cfg_ready_q <= 1'b0;
          end else beat_q <= beat_q + BW'(1);
        end
        EVAL: if (sample) begin
          set_q <= '0;
          fit_q <= fit_q + hit;
`ifdef FIT_ABORT_EN
          err_q <= err_d;
          if (stop_early) aborted_q <= 1'b1;
`endif
          if (last_vec || stop_early) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else vec_q <= vec_q + IN'(1);
        end else set_q <= set_q + STW'(1);
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_genome_fitness_ctrl.sv
// Directed bench for genome_fitness_ctrl on a 2x2 grid, IN=2, OUT=1, SETTLE=1, with a behavioural grid and registered target ROM.
module tb_genome_fitness_ctrl;
  localparam int FW = 3;
`ifdef FIT_ABORT_EN
  localparam int MAXE = 1;
`else
  localparam int MAXE = 8;
`endif

  logic        clk = 1'b0;
  logic        rst, start, reuse, cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_ready, busy, done;
  logic [63:0] saidas_LE;
  logic [1:0]  out_chrom, inp, tgt_addr;
  logic [0:0]  out_w, tgt_data;
  logic [FW-1:0] fitness;
`ifdef FIT_ABORT_EN
  logic        aborted;
`endif

  always #5 clk = ~clk;

  genome_fitness_ctrl #(.ROW(2), .COL(2), .IN(2), .OUT(1), .CFG_W(32), .SETTLE(1), .MAX_ERR(MAXE)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse(reuse),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .saidas_LE(saidas_LE), .out_chrom(out_chrom), .inp(inp), .out(out_w),
    .tgt_addr(tgt_addr), .tgt_data(tgt_data), .busy(busy), .done(done),
`ifdef FIT_ABORT_EN
    .aborted(aborted),
`endif
    .fitness(fitness));

  // Grid model: the selected cell's LUT indexed by the input vector.
  logic [15:0] lut;
  always_comb begin
    lut   = saidas_LE[int'(out_chrom)*16 +: 16];
    out_w = lut[inp];
  end

  logic [3:0] tgt_rom;
  always @(posedge clk) tgt_data <= tgt_rom[tgt_addr];

  int checks = 0, errors = 0;
  logic [31:0] beats [3];
  int tr_inp [20], tr_addr [20];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input bit ru, input bit gap, input int pulse_at, input int rst_at,
                     output int cyc, output logic [FW-1:0] fit, output int nbeats,
                     output bit saw_ready, output bit got_done);
    int  bidx = 0;
    bit  acc  = 0;
    saw_ready = 0;
    got_done  = 0;
    @(negedge clk); start = 1; reuse = ru; cfg_valid = 0;
    @(negedge clk); start = 0; reuse = 0; cyc = 1;
    while (cyc < 200) begin
      if (acc) bidx++;
      if (cfg_ready) saw_ready = 1;
      tr_inp[cyc % 20]  = int'(inp);
      tr_addr[cyc % 20] = int'(tgt_addr);
      if (done) begin got_done = 1; break; end
      if (cyc == rst_at + 1) begin rst = 0; break; end
      if (cyc == rst_at) rst = 1;
      start     = (cyc == pulse_at);
      cfg_valid = (bidx < 3) && (!gap || cyc[0]);
      cfg_data  = (bidx < 3) ? beats[bidx] : 32'h0;
      acc       = cfg_valid && cfg_ready;
      @(negedge clk); cyc++;
    end
    start = 0; cfg_valid = 0;
    fit = fitness;
    nbeats = bidx;
  endtask

  int          cyc, nb;
  logic [FW-1:0] fit;
  bit          sr, gd;

  initial begin
    rst = 1; start = 0; reuse = 0; cfg_valid = 0; cfg_data = '0; tgt_rom = 4'b1111;
    // Upper bits of the last beat lie past CFG_BITS and must be dropped.
    beats[0] = 32'hFFFF_FFFF; beats[1] = 32'hFFFF_FFFF; beats[2] = 32'hDEAD_BEEC;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_fit", fitness, 0);
    chk("rst_lut", saidas_LE, 0);
    chk("rst_inp", inp, 0);
    rst = 0;

    // 1: full load, all-ones target
    run(0, 0, -1, -1, cyc, fit, nb, sr, gd);
    chk("t1_done", gd, 1);
    chk("t1_lat", cyc, 12);
    chk("t1_fit", fit, 4);
    chk("t1_beats", nb, 3);
    chk("t1_lut", saidas_LE, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_sel", out_chrom, 0);
`ifdef FIT_ABORT_EN
    chk("t1_abort", aborted, 0);
`endif

    // 3: gapped beats give the same chromosome
    run(0, 1, -1, -1, cyc, fit, nb, sr, gd);
    chk("t3_done", gd, 1);
    chk("t3_fit", fit, 4);
    chk("t3_beats", nb, 3);
    chk("t3_lut", saidas_LE, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_sel", out_chrom, 0);

    // 2 + 5: reuse with target 0110, trace the vector sweep
    tgt_rom = 4'b0110;
    run(1, 0, -1, -1, cyc, fit, nb, sr, gd);
    chk("t2_done", gd, 1);
    chk("t2_lat", cyc, 9);
    chk("t2_fit", fit, 2);
    chk("t2_noready", sr, 0);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t5_inp%0d", c), tr_inp[c], (c - 1) / 2);
      chk($sformatf("t5_addr%0d", c), tr_addr[c], tr_inp[c]);
    end
    chk("t5_nowrap", tr_inp[9], 3);

    // 4: start during EVAL is ignored
    run(0, 0, 6, -1, cyc, fit, nb, sr, gd);
    chk("t4_done", gd, 1);
    chk("t4_lat", cyc, 12);
    chk("t4_fit", fit, 2);

    // 4: reset mid-EVAL clears everything
    run(0, 0, -1, 6, cyc, fit, nb, sr, gd);
    chk("t4r_busy", busy, 0);
    chk("t4r_fit", fitness, 0);
    chk("t4r_lut", saidas_LE, 0);
    run(1, 0, -1, -1, cyc, fit, nb, sr, gd);
    chk("t4z_done", gd, 1);
`ifdef FIT_ABORT_EN
    chk("t4z_lat", cyc, 7);
    chk("t4z_fit", fit, 1);
`else
    chk("t4z_lat", cyc, 9);
    chk("t4z_fit", fit, 2);
`endif

`ifdef FIT_ABORT_EN
    // 6: zero chromosome vs all-ones target aborts after vector 1
    tgt_rom = 4'b1111;
    run(1, 0, -1, -1, cyc, fit, nb, sr, gd);
    chk("t6_done", gd, 1);
    chk("t6_lat", cyc, 5);
    chk("t6_fit", fit, 0);
    chk("t6_abort", aborted, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
